// File: rtl/qqspi_arb_pkg.sv
// Shared definitions for the qqspi two-master arbiter: FSM encoding, master
// indices, default address windows and the window-compare helper.
package qqspi_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic MST_0 = 1'b0;
  localparam logic MST_1 = 1'b1;

  localparam logic [31:0] DEF_NOR_START   = 32'h2000_0000;
  localparam logic [31:0] DEF_NOR_END     = 32'h2100_0000;
  localparam logic [31:0] DEF_PSRAM_START = 32'h8000_0000;
  localparam logic [31:0] DEF_PSRAM_END   = 32'h8080_0000;
  localparam int          DEF_WORD_ADDR_W = 23;

  // One master's request as seen by the arbiter.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mst_req_t;

  // Unsigned window test: start inclusive, stop exclusive.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] start,
                                     input logic [31:0] stop);
    return (addr >= start) && (addr < stop);
  endfunction

endpackage

// File: rtl/qqspi_addr_decode.sv
// Combinational region decode: selects NOR or PSRAM, flags illegal accesses
// and forms the window-relative word address for qqspi.
module qqspi_addr_decode
  import qqspi_arb_pkg::*;
#(
  parameter logic [31:0] NOR_START   = DEF_NOR_START,
  parameter logic [31:0] NOR_END     = DEF_NOR_END,
  parameter logic [31:0] PSRAM_START = DEF_PSRAM_START,
  parameter logic [31:0] PSRAM_END   = DEF_PSRAM_END,
  parameter int          WORD_ADDR_W = DEF_WORD_ADDR_W
) (
  input  logic [31:0]            addr,
  input  logic [3:0]             wstrb,
  output logic                   nor_sel,
  output logic                   psram_sel,
  output logic                   fault,
  output logic [WORD_ADDR_W-1:0] word_addr
);

  logic        in_nor;
  logic        in_psram;
  logic [31:0] offset;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    in_nor    = in_window(addr, NOR_START, NOR_END);
    in_psram  = in_window(addr, PSRAM_START, PSRAM_END);
    // The flash window is read-only; programming goes through a separate path.
    nor_sel   = in_nor && (wstrb == 4'b0000);
    psram_sel = in_psram;
    fault     = !(nor_sel || psram_sel);
    offset    = addr - (in_psram ? PSRAM_START : NOR_START);
    word_addr = WORD_ADDR_W'(offset >> 2);
  end

endmodule

// File: rtl/qqspi_arbiter.sv
// Two-master round-robin arbiter and region decoder in front of qqspi.
// Optional ownership locking for atomic RMW is enabled by QQSPI_ARB_LOCK_EN.
module qqspi_arbiter
  import qqspi_arb_pkg::*;
#(
  parameter logic [31:0] NOR_START   = DEF_NOR_START,
  parameter logic [31:0] NOR_END     = DEF_NOR_END,
  parameter logic [31:0] PSRAM_START = DEF_PSRAM_START,
  parameter logic [31:0] PSRAM_END   = DEF_PSRAM_END,
  parameter int          WORD_ADDR_W = DEF_WORD_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   m0_valid,
  input  logic [31:0]            m0_addr,
  input  logic [31:0]            m0_wdata,
  input  logic [3:0]             m0_wstrb,
  output logic                   m0_ready,
  output logic [31:0]            m0_rdata,
  output logic                   m0_fault,

  input  logic                   m1_valid,
  input  logic [31:0]            m1_addr,
  input  logic [31:0]            m1_wdata,
  input  logic [3:0]             m1_wstrb,
  output logic                   m1_ready,
  output logic [31:0]            m1_rdata,
  output logic                   m1_fault,

`ifdef QQSPI_ARB_LOCK_EN
  input  logic                   m0_lock,
  input  logic                   m1_lock,
`endif

  output logic                   q_valid,
  output logic [WORD_ADDR_W-1:0] q_addr,
  output logic [31:0]            q_wdata,
  output logic [3:0]             q_wstrb,
  output logic                   q_psram_spiflash,
  output logic [2:0]             q_ce_ctrl,
  input  logic                   q_ready,
  input  logic [31:0]            q_rdata
);

  logic [1:0]             state;
  logic                   grant_r;
  logic                   rr_last;
  logic                   fault_r;
  logic                   nor_r;
  logic                   psram_r;
  logic [WORD_ADDR_W-1:0] addr_r;
  logic [31:0]            wdata_r;
  logic [3:0]             wstrb_r;
  logic [31:0]            rdata_r;

`ifdef QQSPI_ARB_LOCK_EN
  logic                   lock_r;
  logic                   locked_r;
`endif

  logic                   req0;
  logic                   req1;
  logic                   pick;
  mst_req_t               m0_req;
  mst_req_t               m1_req;
  mst_req_t               sel_req;

  logic                   dec_nor;
  logic                   dec_psram;
  logic                   dec_fault;
  logic [WORD_ADDR_W-1:0] dec_addr;

  assign m0_req = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  always_comb begin
    req0 = m0_valid;
    req1 = m1_valid;
`ifdef QQSPI_ARB_LOCK_EN
    // While a lock is held only the owner (last granted master) may win.
    if (locked_r) begin
      req0 = m0_valid && (grant_r == MST_0);
      req1 = m1_valid && (grant_r == MST_1);
    end
`endif
    if (req0 && req1) pick = ~rr_last;
    else if (req1)    pick = MST_1;
    else              pick = MST_0;
    sel_req = (pick == MST_1) ? m1_req : m0_req;
  end

  qqspi_addr_decode #(
    .NOR_START   (NOR_START),
    .NOR_END     (NOR_END),
    .PSRAM_START (PSRAM_START),
    .PSRAM_END   (PSRAM_END),
    .WORD_ADDR_W (WORD_ADDR_W)
  ) u_decode (
    .addr      (sel_req.addr),
    .wstrb     (sel_req.wstrb),
    .nor_sel   (dec_nor),
    .psram_sel (dec_psram),
    .fault     (dec_fault),
    .word_addr (dec_addr)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant_r  <= MST_0;
      rr_last  <= MST_1;
      fault_r  <= 1'b0;
      nor_r    <= 1'b0;
      psram_r  <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      wstrb_r  <= '0;
      rdata_r  <= '0;
`ifdef QQSPI_ARB_LOCK_EN
      lock_r   <= 1'b0;
      locked_r <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            grant_r <= pick;
            addr_r  <= dec_addr;
            wdata_r <= sel_req.wdata;
            wstrb_r <= sel_req.wstrb;
            nor_r   <= dec_nor;
            psram_r <= dec_psram;
            fault_r <= dec_fault;
            rdata_r <= '0;
`ifdef QQSPI_ARB_LOCK_EN
            lock_r  <= (pick == MST_1) ? m1_lock : m0_lock;
`endif
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A faulting access spends this cycle with q_valid suppressed, which
          // puts its response two cycles after the request like the spec'd t+2.
          if (fault_r) begin
            state <= ST_RESP;
          end else if (q_ready) begin
            rdata_r <= q_rdata;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
`ifdef QQSPI_ARB_LOCK_EN
          locked_r <= lock_r;
          if (!lock_r) rr_last <= grant_r;
`else
          rr_last <= grant_r;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign q_valid          = (state == ST_ISSUE) && !fault_r;
  assign q_addr           = q_valid ? addr_r  : '0;
  assign q_wdata          = q_valid ? wdata_r : '0;
  assign q_wstrb          = q_valid ? wstrb_r : '0;
  assign q_psram_spiflash = q_valid && psram_r;
  assign q_ce_ctrl        = q_valid ? {1'b0, psram_r, nor_r} : 3'b000;

  assign m0_ready = (state == ST_RESP) && (grant_r == MST_0);
  assign m1_ready = (state == ST_RESP) && (grant_r == MST_1);
  assign m0_rdata = m0_ready ? rdata_r : '0;
  assign m1_rdata = m1_ready ? rdata_r : '0;
  assign m0_fault = m0_ready && fault_r;
  assign m1_fault = m1_ready && fault_r;

endmodule

// File: tb/tb_qqspi_arbiter.sv
// Randomized self-checking bench for qqspi_arbiter with a transaction-level
// reference model; the lock test runs when QQSPI_ARB_LOCK_EN is defined.
module tb_qqspi_arbiter;

  localparam logic [31:0] NOR_S = 32'h2000_0000;
  localparam logic [31:0] NOR_E = 32'h2100_0000;
  localparam logic [31:0] PS_S  = 32'h8000_0000;
  localparam logic [31:0] PS_E  = 32'h8080_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, m0_fault, m1_fault;
  logic [31:0] m0_rdata, m1_rdata;
  logic        q_valid, q_psram_spiflash, q_ready;
  logic [22:0] q_addr;
  logic [31:0] q_wdata, q_rdata;
  logic [3:0]  q_wstrb;
  logic [2:0]  q_ce_ctrl;
`ifdef QQSPI_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  qqspi_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
`ifdef QQSPI_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .q_valid(q_valid), .q_addr(q_addr), .q_wdata(q_wdata), .q_wstrb(q_wstrb),
    .q_psram_spiflash(q_psram_spiflash), .q_ce_ctrl(q_ce_ctrl),
    .q_ready(q_ready), .q_rdata(q_rdata)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic rr_m;                               // model: last master served
  req_t cur [2];
  logic [31:0] ps_mem  [logic [31:0]];      // model PSRAM, keyed by byte address
  logic [31:0] rsp_mem [logic [22:0]];      // responder PSRAM, keyed by q_addr

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] flash_word(input logic [31:0] ba);
    return {ba[31:2], 2'b00} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ps_default(input logic [31:0] ba);
    return {ba[31:2], 2'b00} ^ 32'hC3C3_0000;
  endfunction

  task automatic drive_m(input int m, input logic v);
    if (m == 0) begin
      m0_valid = v; m0_addr = cur[0].addr; m0_wdata = cur[0].wdata; m0_wstrb = cur[0].wstrb;
    end else begin
      m1_valid = v; m1_addr = cur[1].addr; m1_wdata = cur[1].wdata; m1_wstrb = cur[1].wstrb;
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    case ($urandom_range(0, 11))
      0, 1:    r.addr = NOR_S + ($urandom_range(0, 1023) << 2);
      2, 3, 4: r.addr = PS_S + ($urandom_range(0, 31) << 2);
      5:       r.addr = NOR_E - 4;
      6:       r.addr = PS_E - 4;
      7:       r.addr = NOR_E;
      8:       r.addr = PS_E;
      9:       r.addr = NOR_S - 4;
      10:      r.addr = PS_S;
      default: r.addr = $urandom & 32'hFFFF_FFFC;
    endcase
    r.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    r.wdata = $urandom;
    return r;
  endfunction

  // Entered at the negedge of a cycle where the DUT is idle and master m is
  // the expected winner with valid already high. Returns at its ready cycle.
  task automatic serve(input int m, input int lat, input bit upd_rr);
    logic [31:0] a, base, exp_rd, rsp, junk;
    logic        is_nor, is_ps, flt, rd;
    a      = cur[m].addr;
    rd     = (cur[m].wstrb == 4'h0);
    is_nor = (a >= NOR_S) && (a < NOR_E);
    is_ps  = (a >= PS_S) && (a < PS_E);
    flt    = !(is_ps || (is_nor && rd));
    if ($urandom_range(0, 3) == 0) begin
      q_ready = 1'b1;
      q_rdata = $urandom;
    end
    @(negedge clk);
    q_ready = 1'b0;
    q_rdata = '0;
    if (flt) begin
      check("fault_no_qvalid", q_valid, 0);
      check("fault_early_ready", m0_ready | m1_ready, 0);
      @(negedge clk);
      check("fault_ready", (m == 0) ? m0_ready : m1_ready, 1);
      check("fault_flag", (m == 0) ? m0_fault : m1_fault, 1);
      check("fault_rdata", (m == 0) ? m0_rdata : m1_rdata, 0);
      check("fault_other_ready", (m == 0) ? m1_ready : m0_ready, 0);
      check("fault_no_qvalid2", q_valid, 0);
    end else begin
      base = is_ps ? PS_S : NOR_S;
      check("q_valid", q_valid, 1);
      check("q_addr", q_addr, (a - base) >> 2);
      check("q_ce_ctrl", q_ce_ctrl, is_ps ? 3'b010 : 3'b001);
      check("q_psram", q_psram_spiflash, is_ps);
      check("q_wstrb", q_wstrb, cur[m].wstrb);
      check("q_wdata", q_wdata, cur[m].wdata);
      repeat (lat) begin
        @(negedge clk);
        check("hold", {q_valid, m0_ready, m1_ready}, 3'b100);
      end
      // Responder side: acts only on what the DUT presents.
      junk = $urandom;
      if (q_psram_spiflash) begin
        rsp = rsp_mem.exists(q_addr) ? rsp_mem[q_addr] : ps_default(PS_S + {q_addr, 2'b00});
        if (q_wstrb != 4'h0) begin
          rsp_mem[q_addr] = merge(rsp, q_wdata, q_wstrb);
          rsp = junk;
        end
      end else begin
        rsp = flash_word(NOR_S + {q_addr, 2'b00});
      end
      // Reference model side: byte-address view.
      if (!rd) begin
        exp_rd = ps_mem.exists(a & ~32'h3) ? ps_mem[a & ~32'h3] : ps_default(a);
        ps_mem[a & ~32'h3] = merge(exp_rd, cur[m].wdata, cur[m].wstrb);
        exp_rd = junk;
      end else if (is_ps) begin
        exp_rd = ps_mem.exists(a & ~32'h3) ? ps_mem[a & ~32'h3] : ps_default(a);
      end else begin
        exp_rd = flash_word(a);
      end
      q_ready = 1'b1;
      q_rdata = rsp;
      @(negedge clk);
      q_ready = 1'b0;
      q_rdata = '0;
      check("ready", (m == 0) ? m0_ready : m1_ready, 1);
      check("rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
      check("no_fault", (m == 0) ? m0_fault : m1_fault, 0);
      check("other_ready", (m == 0) ? m1_ready : m0_ready, 0);
      check("q_valid_drop", q_valid, 0);
    end
    drive_m(m, 1'b0);
    if (upd_rr) rr_m = m[0];
  endtask

  // Both masters request in the same cycle; model picks the non-last one.
  task automatic tie_round();
    int first;
    first = (rr_m == 1'b1) ? 0 : 1;
    drive_m(0, 1'b1);
    drive_m(1, 1'b1);
    serve(first, $urandom_range(0, 5), 1'b1);
    @(negedge clk);
    serve(1 - first, $urandom_range(0, 5), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; q_ready = 1'b0; q_rdata = '0; rr_m = 1'b1;
    cur[0] = '{32'h0, 32'h0, 4'h0};
    cur[1] = '{32'h0, 32'h0, 4'h0};
    drive_m(0, 1'b0);
    drive_m(1, 1'b0);
`ifdef QQSPI_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_ce", q_ce_ctrl, 0);
    check("rst_q_addr", q_addr, 0);
    check("rst_ready", {m0_ready, m1_ready, m0_fault, m1_fault}, 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // m0 flash read, 20-cycle qqspi latency
    cur[0] = '{32'h2000_0010, 32'h0, 4'h0};
    drive_m(0, 1'b1);
    serve(0, 19, 1'b1);
    @(negedge clk);

    // m1 PSRAM half-word write
    cur[1] = '{32'h8000_0100, 32'hCAFE_F00D, 4'b0011};
    drive_m(1, 1'b1);
    serve(1, 3, 1'b1);
    @(negedge clk);

    // Faults: NOR write, then read at the PSRAM end address
    cur[0] = '{32'h2000_0000, 32'h1234_5678, 4'hF};
    drive_m(0, 1'b1);
    serve(0, 0, 1'b1);
    @(negedge clk);
    cur[0] = '{32'h8080_0000, 32'h0, 4'h0};
    drive_m(0, 1'b1);
    serve(0, 0, 1'b1);
    @(negedge clk);

    // Back-to-back ties must alternate
    for (int i = 0; i < 4; i++) begin
      cur[0] = rand_req();
      cur[1] = rand_req();
      tie_round();
      @(negedge clk);
    end

    // Reset while a transfer is in flight
    cur[0] = '{NOR_S + 32'h40, 32'h0, 4'h0};
    drive_m(0, 1'b1);
    @(negedge clk);
    check("pre_rst_q_valid", q_valid, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    drive_m(0, 1'b0);
    @(negedge clk);
    check("mid_rst_q_valid", q_valid, 0);
    check("mid_rst_ready", {m0_ready, m1_ready}, 0);
    rst_n = 1'b1;
    rr_m  = 1'b1;
    @(negedge clk);
    cur[1] = '{PS_S + 32'h100, 32'h0, 4'h0};
    drive_m(1, 1'b1);
    serve(1, 2, 1'b1);
    @(negedge clk);

`ifdef QQSPI_ARB_LOCK_EN
    // m0 locked read then unlocked write; m1 pending must wait for both
    cur[0] = '{PS_S + 32'h200, 32'h0, 4'h0};
    cur[1] = '{PS_S + 32'h200, 32'h0, 4'h0};
    m0_lock = 1'b1;
    drive_m(0, 1'b1);
    drive_m(1, 1'b1);
    serve(0, 2, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check("lock_hold_q_valid", q_valid, 0);
      check("lock_hold_m1_ready", m1_ready, 0);
    end
    cur[0] = '{PS_S + 32'h200, 32'h0000_0055, 4'b0001};
    m0_lock = 1'b0;
    drive_m(0, 1'b1);
    serve(0, 1, 1'b1);
    @(negedge clk);
    serve(1, 1, 1'b1);
    @(negedge clk);
`endif

    // Randomized traffic
    for (int r = 0; r < 150; r++) begin
      int mode;
      mode = $urandom_range(0, 2);
      cur[0] = rand_req();
      cur[1] = rand_req();
      if (mode == 2) begin
        tie_round();
      end else begin
        drive_m(mode, 1'b1);
        serve(mode, $urandom_range(0, 5), 1'b1);
      end
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
